// File: rtl/mx_block_acc_pkg.sv
// Shared types, default widths and the overflow-aware adder for the MX block accumulator.
package mx_pkg;

  localparam int MX_SUM_W     = 21;
  localparam int MX_ACC_W     = 48;
  localparam int MX_SHIFT_MAX = 15;
  localparam int MX_CNT_W     = 16;
  localparam int MX_WMAX      = 64;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  typedef struct packed {
    logic               ovf;
    logic [MX_WMAX-1:0] res;
  } sat_res_t;

  // Operands live in a 64-bit container; only the low w bits are meaningful.
  function automatic sat_res_t sat_add(input logic [MX_WMAX-1:0] a,
                                       input logic [MX_WMAX-1:0] b,
                                       input int unsigned        w,
                                       input logic               sat_en);
    logic [MX_WMAX-1:0] s;
    logic [MX_WMAX-1:0] smin;
    logic [MX_WMAX-1:0] smax;
    logic [5:0]         msb;
    sat_res_t           r;
    msb   = 6'(w - 1);
    s     = a + b;
    smin  = MX_WMAX'(1) << msb;
    smax  = smin - MX_WMAX'(1);
    r.ovf = (a[msb] == b[msb]) && (s[msb] != a[msb]);
    r.res = s;
    if (r.ovf && sat_en) begin
      r.res = a[msb] ? smin : smax;
    end
    return r;
  endfunction

endpackage

// File: rtl/mx_block_acc_if.sv
// Beat-in / result-out handshake bundle for mx_block_acc.
interface mx_block_acc_if
  import mx_pkg::*;
#(
  parameter int SUM_W   = MX_SUM_W,
  parameter int SHIFT_W = $clog2(MX_SHIFT_MAX + 1),
  parameter int ACC_W   = MX_ACC_W,
  parameter int CNT_W   = MX_CNT_W
);
  logic               i_valid;
  logic               o_ready;
  logic [SUM_W-1:0]   i_sum;
  logic [SHIFT_W-1:0] i_shift;
  logic               i_last;
  logic               o_valid;
  logic               i_ready;
  logic [ACC_W-1:0]   o_acc;
  logic [CNT_W-1:0]   o_count;
  logic               o_ovf;

  modport slave (
    input  i_valid, i_sum, i_shift, i_last, i_ready,
    output o_ready, o_valid, o_acc, o_count, o_ovf
  );

  modport master (
    output i_valid, i_sum, i_shift, i_last, i_ready,
    input  o_ready, o_valid, o_acc, o_count, o_ovf
  );
endinterface

// File: rtl/mx_block_acc_align_shift.sv
// Sign-extends a partial sum to accumulator width and applies the clamped alignment shift.
module mx_align_shift
  import mx_pkg::*;
#(
  parameter int SUM_W     = MX_SUM_W,
  parameter int SHIFT_MAX = MX_SHIFT_MAX,
  parameter int SHIFT_W   = $clog2(SHIFT_MAX + 1),
  parameter int ACC_W     = MX_ACC_W
) (
  input  logic [SUM_W-1:0]   i_sum,
  input  logic [SHIFT_W-1:0] i_shift,
  output logic [ACC_W-1:0]   o_term
);
  logic [SHIFT_W:0] w_shift_wide;
  logic [SHIFT_W:0] w_sh;
  logic [ACC_W-1:0] w_ext;

  assign w_shift_wide = {1'b0, i_shift};
  assign w_sh  = (w_shift_wide > (SHIFT_W + 1)'(SHIFT_MAX)) ? (SHIFT_W + 1)'(SHIFT_MAX)
                                                            : w_shift_wide;
  assign w_ext  = ACC_W'(signed'(i_sum));
  assign o_term = w_ext << w_sh;
endmodule

// File: rtl/mx_block_acc.sv
// Streaming shift-align accumulator with valid/ready result hold.
// Build option: MX_BLOCK_ACC_SAT_EN clamps the accumulator on signed overflow.
module mx_block_acc
  import mx_pkg::*;
#(
  parameter int SUM_W     = MX_SUM_W,
  parameter int SHIFT_MAX = MX_SHIFT_MAX,
  parameter int SHIFT_W   = $clog2(SHIFT_MAX + 1),
  parameter int ACC_W     = MX_ACC_W,
  parameter int CNT_W     = MX_CNT_W
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  mx_block_acc_if.slave  bus
);
`ifdef MX_BLOCK_ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_out_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_ovf;
  logic             r_out_ovf;
  logic             r_valid;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_add;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_fire;
  sat_res_t         w_sr;

  mx_align_shift #(
    .SUM_W     (SUM_W),
    .SHIFT_MAX (SHIFT_MAX),
    .SHIFT_W   (SHIFT_W),
    .ACC_W     (ACC_W)
  ) u_align (
    .i_sum   (bus.i_sum),
    .i_shift (bus.i_shift),
    .o_term  (w_term)
  );

  assign w_fire    = bus.i_valid && (r_state != HOLD);
  assign w_sr      = sat_add(MX_WMAX'(r_acc), MX_WMAX'(w_term), ACC_W, SAT_EN);
  assign w_add     = w_sr.res[ACC_W-1:0];
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  generate
    if (ACC_W < MX_WMAX) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^w_sr.res[MX_WMAX-1:ACC_W];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ACC: if (bus.i_valid) w_next = bus.i_last ? HOLD : ACC;
      HOLD:      if (bus.i_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // The first beat of a run loads rather than adds, which also restarts the sticky flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_out_acc <= '0;
      r_out_cnt <= '0;
      r_out_ovf <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      if (w_fire) begin
        if (r_state == IDLE) begin
          if (bus.i_last) begin
            r_out_acc <= w_term;
            r_out_cnt <= CNT_W'(1);
            r_out_ovf <= 1'b0;
          end else begin
            r_acc <= w_term;
            r_cnt <= CNT_W'(1);
            r_ovf <= 1'b0;
          end
        end else begin
          if (bus.i_last) begin
            r_out_acc <= w_add;
            r_out_cnt <= w_cnt_inc;
            r_out_ovf <= r_ovf | w_sr.ovf;
          end else begin
            r_acc <= w_add;
            r_cnt <= w_cnt_inc;
            r_ovf <= r_ovf | w_sr.ovf;
          end
        end
      end
      r_valid <= (w_next == HOLD);
    end
  end

  assign bus.o_ready = (r_state != HOLD);
  assign bus.o_valid = r_valid;
  assign bus.o_acc   = r_out_acc;
  assign bus.o_count = r_out_cnt;
  assign bus.o_ovf   = r_out_ovf;
endmodule

// File: doc/mx_block_acc.md
Name: mx_block_acc

Overview:
- Streaming accumulator directly downstream of the int8 vector adder tree.
- Takes one per-block partial sum per beat and left-shifts it by a per-beat alignment amount derived from the MX shared scales.
- Accumulates a run of beats terminated by a last flag, then presents the final dot-product result on a valid/ready output held until accepted.

Parameters:
- sum_width, 21, width of incoming partial sum (adder tree output: 16 + log2(32)).
- shift_max, 15, largest legal per-beat left shift.
- shift_width, $clog2(shift_max+1), width of i_shift.
- acc_width, 48, accumulator and result width; must be >= sum_width + shift_max + 1.
- cnt_width, 16, beat-counter width.

Ports:
- i_clk  input  1  clock; single clock domain.
- i_rst_n  input  1  reset; synchronous, active-low.
- i_valid  input  1  input beat valid.
- o_ready  output  1  block can accept an input beat.
- i_sum  input  sum_width  partial sum, two's complement signed.
- i_shift  input  shift_width  left-shift alignment for this beat.
- i_last  input  1  final beat of the current run.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_acc  output  acc_width  accumulated result, signed.
- o_count  output  cnt_width  number of beats in the result.
- o_ovf  output  1  overflow occurred during this run.

Behaviour:
- Reset (i_rst_n low at a clock edge): state IDLE; accumulator, o_acc, o_count and o_ovf are 0; o_valid = 0.
- Reset mid-run or mid-HOLD discards the partial and pending result; no output is produced.
- Input handshake: a beat is accepted when i_valid && o_ready at the clock edge.
- o_ready = (state != HOLD). It is registered-state derived and has no combinational path from i_ready.
- Per accepted beat: term = sign_extend(i_sum, acc_width) << i_shift.
- i_shift > shift_max is clamped to shift_max.
- FSM states: IDLE, ACC, HOLD.
  - IDLE, beat without last: acc <= term, cnt <= 1, go to ACC.
  - IDLE, beat with last: single-beat run; o_acc <= term, o_count <= 1, go to HOLD.
  - ACC, beat without last: acc <= acc + term, cnt <= cnt + 1.
  - ACC, beat with last: o_acc <= acc + term, o_count <= cnt + 1, go to HOLD.
  - HOLD: o_valid = 1; o_acc, o_count and o_ovf are stable. On i_ready go to IDLE.
  - In HOLD, o_ready is 0 and input is backpressured.
- Latency: o_valid rises the cycle after the last beat is accepted.
- Throughput: one run per (N+1) cycles minimum, where N is the beat count.
- Arithmetic: acc_width two's complement.
  - Signed overflow on any add (operand signs equal, result sign differs) sets the sticky run flag. The flag is cleared on entering a new run.
  - o_ovf = flag at result time.
  - Without saturation (see Optional Feature), the sum wraps modulo 2^acc_width.
- Beat counter saturates at 2^cnt_width-1 and does not wrap.
- i_valid low in ACC: state holds; the run may idle indefinitely.
- o_valid and o_acc are driven from registers only.

Optional Feature:
- Macro: MX_BLOCK_ACC_SAT_EN.
- Defined: on overflow the accumulator clamps to the signed max (positive overflow) or signed min (negative overflow). The clamped value persists and further adds continue from it. o_ovf is still reported.
- Undefined: wrap-around arithmetic; o_ovf is still reported.
- Port list is identical in both builds.

Decomposition:
- Shared package mx_pkg holds:
  - the FSM state enum (IDLE/ACC/HOLD);
  - default widths (MX_SUM_W = 21, MX_ACC_W = 48, MX_SHIFT_MAX = 15);
  - a function sat_add(a, b, sat_en) returning {ovf, result}.
- One sub-module is natural: mx_align_shift (sign-extend, clamp, shift; purely combinational). The FSM and accumulator stay in mx_block_acc.

Test Plan:
- Single beat: i_sum = -5, i_shift = 2, i_last = 1 → next cycle o_valid = 1, o_acc = -20, o_count = 1, o_ovf = 0.
- Four-beat run: sums 100, -3, 7, 1 with shifts 0, 1, 3, 0 and last on beat 4 → o_acc = 151, o_count = 4; o_ready = 0 until i_ready is asserted.
- Backpressure: hold i_ready = 0 for 10 cycles in HOLD → o_acc and o_count stable, o_ready = 0, input beats not consumed. Assert i_ready → IDLE next cycle and a new beat is accepted.
- Overflow: acc_width = 24, sum = 2^20-1 at shift 3 twice → o_ovf = 1. o_acc = wrapped value, or 2^23-1 with MX_BLOCK_ACC_SAT_EN.
- Clamp and gaps: i_shift = 31 with shift_max = 15, i_sum = 1 → term = 32768. i_valid gaps mid-run do not alter acc.
- Reset mid-run: two beats accepted, then i_rst_n = 0 for one edge → o_valid = 0, o_acc = 0. Next single-beat run with sum 9 → o_acc = 9, o_count = 1.
